// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer.
//   op_e    : operation a requester asks for
//   state_e : sequencer FSM states
package counter_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_ADD_N = 2'd1,
    OP_SUB_N = 2'd2,
    OP_READ  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/counter_sequencer_rr_arbiter.sv
// Round-robin arbiter (module rr_arbiter).
// The search starts at ptr_i and wraps; the first asserted request wins.
//   req_i   : request vector
//   ptr_i   : index where the search starts
//   gnt_o   : one-hot grant
//   idx_o   : index of the granted requester
//   valid_o : some request was granted
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  int   cand;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr_i) + i) % N;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/counter_sequencer.sv
// Shares one up/down/load counter between NUM_REQ requesters.
// Round-robin grant in IDLE, op sequenced one counter strobe per cycle,
// one-cycle ack carrying the post-op count.
//   clk, reset_n          : clock, async active-low reset
//   req/req_op/req_data   : per-requester request, op_e, operand
//   ack/rsp_data          : one-hot completion pulse and counter value
//   busy                  : FSM not in IDLE
//   cnt_in/cnt_load/cnt_down/cnt_enable : registered counter controls
//   cnt_value             : counter output
//
// state | meaning
// IDLE  | waiting; arbitrate and latch the winning op
// EXEC  | one counter strobe per cycle until the step count runs out
// DONE  | ack granted requester with the post-op counter value
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int STEP_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*2-1:0]     req_op,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy,
  output logic [WIDTH-1:0]         cnt_in,
  output logic                     cnt_load,
  output logic                     cnt_down,
  output logic                     cnt_enable,
  input  logic [WIDTH-1:0]         cnt_value
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]   cnt_in_q, cnt_in_d;
  logic               load_q, load_d, down_q, down_d, en_q, en_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [1:0]         op_arr   [NUM_REQ];
  logic [WIDTH-1:0]   data_arr [NUM_REQ];
  op_e                win_op;
  logic [WIDTH-1:0]   win_data;
  logic [STEP_W-1:0]  win_steps;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g]   = req_op[2*g +: 2];
    assign data_arr[g] = req_data[WIDTH*g +: WIDTH];
  end

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign win_op    = op_e'(op_arr[arb_idx]);
  assign win_data  = data_arr[arb_idx];
  assign win_steps = win_data[STEP_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      step_q   <= '0;
      gnt_q    <= '0;
      ptr_q    <= '0;
      cnt_in_q <= '0;
      load_q   <= 1'b0;
      down_q   <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      cnt_in_q <= cnt_in_d;
      load_q   <= load_d;
      down_q   <= down_d;
      en_q     <= en_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    cnt_in_d = cnt_in_q;
    load_d   = load_q;
    down_d   = down_q;
    en_d     = en_q;
    case (state_q)
      IDLE: begin
        load_d   = 1'b0;
        down_d   = 1'b0;
        en_d     = 1'b0;
        cnt_in_d = '0;
        if (arb_valid) begin
          gnt_d = arb_gnt;
          ptr_d = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
          state_d = DONE;
          case (win_op)
            OP_LOAD: begin
              load_d   = 1'b1;
              cnt_in_d = win_data;
              step_d   = STEP_W'(1);
              state_d  = EXEC;
            end
            OP_ADD_N, OP_SUB_N: begin
              if (win_steps != '0) begin
                en_d    = (win_op == OP_ADD_N);
                down_d  = (win_op == OP_SUB_N);
                step_d  = win_steps;
                state_d = EXEC;
              end
            end
            default: ;
          endcase
        end
      end
      EXEC: begin
        step_d = step_q - STEP_W'(1);
        // step_q counts the strobe currently on the pins; 1 means it is the last.
        if (step_q == STEP_W'(1)) begin
          load_d   = 1'b0;
          down_d   = 1'b0;
          en_d     = 1'b0;
          cnt_in_d = '0;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rsp_data is taken straight from the counter so the last EXEC step is included.
  always_comb begin
    ack      = (state_q == DONE) ? gnt_q : '0;
    rsp_data = (state_q == DONE) ? cnt_value : '0;
    busy     = (state_q != IDLE);
  end

  assign cnt_in     = cnt_in_q;
  assign cnt_load   = load_q;
  assign cnt_down   = down_q;
  assign cnt_enable = en_q;

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;
  import counter_seq_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic [7:0] req_op;
  logic [31:0] req_data;
  logic [3:0] ack;
  logic [7:0] rsp_data;
  logic       busy;
  logic [7:0] cnt_in;
  logic       cnt_load, cnt_down, cnt_enable;
  logic [7:0] cnt_value;
  logic       cnt_clr;

  int checks = 0;
  int errors = 0;

  counter_sequencer #(.NUM_REQ(4), .WIDTH(8), .STEP_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_op     (req_op),
    .req_data   (req_data),
    .ack        (ack),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .cnt_in     (cnt_in),
    .cnt_load   (cnt_load),
    .cnt_down   (cnt_down),
    .cnt_enable (cnt_enable),
    .cnt_value  (cnt_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter being shared; not reset by reset_n.
  always_ff @(posedge clk) begin
    if (cnt_clr)         cnt_value <= 8'h00;
    else if (cnt_load)   cnt_value <= cnt_in;
    else if (cnt_down)   cnt_value <= cnt_value - 8'd1;
    else if (cnt_enable) cnt_value <= cnt_value + 8'd1;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if ($countones({cnt_load, cnt_down, cnt_enable}) > 1 || $countones(ack) > 1) begin
        errors++;
        $display("FAIL onehot: strobes=%b ack=%b", {cnt_load, cnt_down, cnt_enable}, ack);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    int         idx;
    op_e        op;
    logic [7:0] data;
    logic [7:0] rsp;
    int         lat;
    int         nl;
    int         ne;
    int         nd;
  } vec_t;

  vec_t vecs[11];

  task automatic run_op(input string tag, input int idx, input op_e op, input logic [7:0] data,
                        input logic [7:0] exp_rsp, input int exp_lat, input int exp_nl,
                        input int exp_ne, input int exp_nd, input int chg_at);
    int cyc, nl, ne, nd, bad_in;
    logic got;
    logic [3:0] ack_seen;
    logic [7:0] rsp_seen;
    @(negedge clk);
    req_op[idx*2 +: 2]  = op;
    req_data[idx*8 +: 8] = data;
    req[idx] = 1'b1;
    cyc = 0; nl = 0; ne = 0; nd = 0; bad_in = 0; got = 1'b0;
    ack_seen = '0; rsp_seen = '0;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk({tag, "_busy"}, int'(busy), 1);
      if (cyc == chg_at) begin
        req_op[idx*2 +: 2]  = OP_LOAD;
        req_data[idx*8 +: 8] = 8'h55;
      end
      if (cnt_load) begin
        nl++;
        if (cnt_in != data) bad_in++;
      end else if (cnt_in != 8'h00) bad_in++;
      if (cnt_enable) ne++;
      if (cnt_down) nd++;
      if (ack != 4'b0) begin
        got = 1'b1;
        ack_seen = ack;
        rsp_seen = rsp_data;
      end
    end
    req[idx] = 1'b0;
    chk({tag, "_acked"}, int'(got), 1);
    chk({tag, "_ack"}, int'(ack_seen), 1 << idx);
    chk({tag, "_rsp"}, int'(rsp_seen), int'(exp_rsp));
    chk({tag, "_lat"}, cyc, exp_lat);
    chk({tag, "_nload"}, nl, exp_nl);
    chk({tag, "_nenable"}, ne, exp_ne);
    chk({tag, "_ndown"}, nd, exp_nd);
    chk({tag, "_cnt_in"}, bad_in, 0);
    @(negedge clk);
    chk({tag, "_ack_pulse"}, int'(ack), 0);
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic read_round(input string tag, input logic [7:0] exp_rsp);
    int cyc, prev, k;
    @(negedge clk);
    req_op = 8'hFF;
    req = 4'hF;
    cyc = 0; prev = 0; k = 0;
    while (k < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ack != 4'b0) begin
        chk({tag, "_order"}, int'(ack), 1 << k);
        chk({tag, "_gap"}, cyc - prev, (k == 0) ? 1 : 2);
        chk({tag, "_rsp"}, int'(rsp_data), int'(exp_rsp));
        req = req & ~ack;
        prev = cyc;
        k++;
      end
    end
    req = 4'b0;
    chk({tag, "_count"}, k, 4);
    @(negedge clk);
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int n, cyc;
    vecs[0]  = '{0,  OP_LOAD,  8'h7F, 8'h7F, 2,   1, 0,   0};
    vecs[1]  = '{0,  OP_READ,  8'h00, 8'h7F, 1,   0, 0,   0};
    vecs[2]  = '{1,  OP_LOAD,  8'hFE, 8'hFE, 2,   1, 0,   0};
    vecs[3]  = '{1,  OP_ADD_N, 8'd3,  8'h01, 4,   0, 3,   0};
    vecs[4]  = '{2,  OP_SUB_N, 8'd2,  8'hFF, 3,   0, 0,   2};
    vecs[5]  = '{3,  OP_ADD_N, 8'd0,  8'hFF, 1,   0, 0,   0};
    vecs[6]  = '{3,  OP_READ,  8'hAA, 8'hFF, 1,   0, 0,   0};
    vecs[7]  = '{2,  OP_SUB_N, 8'd0,  8'hFF, 1,   0, 0,   0};
    vecs[8]  = '{1,  OP_ADD_N, 8'd255, 8'hFE, 256, 0, 255, 0};
    vecs[9]  = '{0,  OP_SUB_N, 8'd1,  8'hFD, 2,   0, 0,   1};
    vecs[10] = '{3,  OP_LOAD,  8'h00, 8'h00, 2,   1, 0,   0};

    reset_n = 1'b0;
    req = '0; req_op = '0; req_data = '0;
    cnt_clr = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_rsp", int'(rsp_data), 0);
    chk("rst_strobes", int'({cnt_load, cnt_down, cnt_enable}), 0);
    chk("rst_cnt_in", int'(cnt_in), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;

    // Reset in the middle of ADD_N(5) after two steps
    @(negedge clk);
    req_op[1:0] = OP_ADD_N; req_data[7:0] = 8'd5; req[0] = 1'b1;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cnt_enable) n++;
    end
    chk("mid_steps", n, 2);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    req = '0;
    #1;
    chk("mid_busy", int'(busy), 0);
    chk("mid_ack", int'(ack), 0);
    chk("mid_rsp", int'(rsp_data), 0);
    chk("mid_strobes", int'({cnt_load, cnt_down, cnt_enable}), 0);
    @(negedge clk);
    chk("mid_cnt", int'(cnt_value), 2);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_idle", int'(busy), 0);
    chk("mid_noack", int'(ack), 0);
    chk("mid_cnt_kept", int'(cnt_value), 2);

    // Four simultaneous READs, twice: pointer returns to 0
    read_round("rr1", 8'h02);
    read_round("rr2", 8'h02);

    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].idx, vecs[i].op, vecs[i].data, vecs[i].rsp,
             vecs[i].lat, vecs[i].nl, vecs[i].ne, vecs[i].nd, 0);

    // Operand/op changed during EXEC must be ignored
    run_op("chg", 1, OP_ADD_N, 8'd4, 8'h04, 5, 0, 4, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
